// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the PC sequencer.
//   - funct3 encodings for conditional branches
//   - state enum for the fence drain FSM
// Values that depend on XLEN stay as module parameters in pc_sequencer.
package pc_sequencer_pkg;

  // Branch condition select (funct3)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Fence sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESUME = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// branch_cond
// Combinational branch condition evaluation from funct3 and ALU compare flags.
// Ports:
//   funct3      in  3  branch condition select
//   zero        in  1  operands equal
//   less_than   in  1  signed less-than
//   less_than_u in  1  unsigned less-than
//   cond        out 1  condition true (010/011 never true)
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       less_than,
  input  logic       less_than_u,
  output logic       cond
);
  import pc_sequencer_pkg::*;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = less_than;
      F3_BGE:  cond = ~less_than;
      F3_BLTU: cond = less_than_u;
      F3_BGEU: cond = ~less_than_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program counter sequencer with branch/jump redirection, misaligned-target
// trapping and a FENCE drain FSM (IDLE -> DRAIN -> RESUME -> IDLE).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   stall                           freeze PC advance (IDLE only)
//   branch, jump, jalr, funct3      control-transfer request and condition
//   zero, less_than, less_than_u    ALU compare flags
//   imm, alu_out                    PC-relative offset, jalr target
//   fence, mem_idle                 FENCE request, memory quiescent
//   pc, next_pc                     registered PC, pc+4
//   redirect, misalign, fence_done  registered single-cycle pulses
//   misalign_addr                   offending target of last misalign
//   predecessor, successor          PC of last fence and its fall-through
//   fence_busy, fence_count         fence in progress, saturating count
module pc_sequencer #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = '0,
  parameter logic [XLEN-1:0]   TRAP_VEC  = XLEN'(32'h100),
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              jalr,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              less_than,
  input  logic              less_than_u,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   alu_out,
  input  logic              fence,
  input  logic              mem_idle,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   next_pc,
  output logic              redirect,
  output logic              misalign,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [XLEN-1:0]   predecessor,
  output logic [XLEN-1:0]   successor,
  output logic              fence_busy,
  output logic              fence_done,
  output logic [CNT_W-1:0]  fence_count
);
  import pc_sequencer_pkg::*;

  seq_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
  logic [XLEN-1:0]  predecessor_q, predecessor_d;
  logic [XLEN-1:0]  successor_q, successor_d;
  logic [CNT_W-1:0] fence_count_q, fence_count_d;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic             fence_done_q, fence_done_d;

  logic             cond;
  logic             take;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  target;

  branch_cond u_branch_cond (
    .funct3      (funct3),
    .zero        (zero),
    .less_than   (less_than),
    .less_than_u (less_than_u),
    .cond        (cond)
  );

  assign pc_plus4 = pc_q + XLEN'(4);
  assign take     = jump | (branch & cond);
  // jalr targets drop bit 0; bit 1 is what decides misalignment below.
  assign target   = (jump & jalr) ? {alu_out[XLEN-1:1], 1'b0} : pc_q + imm;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_addr_d = misalign_addr_q;
    predecessor_d   = predecessor_q;
    successor_d     = successor_q;
    fence_count_d   = fence_count_q;
    redirect_d      = 1'b0;
    misalign_d      = 1'b0;
    fence_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!stall) begin
          if (take) begin
            // A taken transfer wins over a simultaneous fence.
            if (target[1]) begin
              pc_d            = TRAP_VEC;
              misalign_d      = 1'b1;
              misalign_addr_d = target;
            end else begin
              pc_d       = target;
              redirect_d = 1'b1;
            end
          end else if (fence) begin
            predecessor_d = pc_q;
            successor_d   = pc_plus4;
            state_d       = ST_DRAIN;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_DRAIN: begin
        // Everything except mem_idle is ignored while draining.
        if (mem_idle) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        pc_d         = successor_q;
        fence_done_d = 1'b1;
        if (fence_count_q != {CNT_W{1'b1}}) begin
          fence_count_d = fence_count_q + CNT_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_VEC;
      misalign_addr_q <= '0;
      predecessor_q   <= '0;
      successor_q     <= '0;
      fence_count_q   <= '0;
      redirect_q      <= 1'b0;
      misalign_q      <= 1'b0;
      fence_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_addr_q <= misalign_addr_d;
      predecessor_q   <= predecessor_d;
      successor_q     <= successor_d;
      fence_count_q   <= fence_count_d;
      redirect_q      <= redirect_d;
      misalign_q      <= misalign_d;
      fence_done_q    <= fence_done_d;
    end
  end

  assign pc            = pc_q;
  assign next_pc       = pc_plus4;
  assign redirect      = redirect_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;
  assign predecessor   = predecessor_q;
  assign successor     = successor_q;
  assign fence_busy    = (state_q != ST_IDLE);
  assign fence_done    = fence_done_q;
  assign fence_count   = fence_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed vector table, hand-written fence/reset sequences and randomized
// stimulus, all checked against a behavioural model of the PC sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jalr, fence, mem_idle;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, imm, alu_out;
  logic        zero, less_than, less_than_u;
  logic [31:0] pc, next_pc, misalign_addr, predecessor, successor;
  logic        redirect, misalign, fence_busy, fence_done;
  logic [7:0]  fence_count;

  // Compare flags are derived from two operand values; the model works
  // from the operands directly.
  assign zero        = (op_a == op_b);
  assign less_than   = ($signed(op_a) < $signed(op_b));
  assign less_than_u = (op_a < op_b);

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
    .jalr(jalr), .funct3(funct3), .zero(zero), .less_than(less_than),
    .less_than_u(less_than_u), .imm(imm), .alu_out(alu_out), .fence(fence),
    .mem_idle(mem_idle), .pc(pc), .next_pc(next_pc), .redirect(redirect),
    .misalign(misalign), .misalign_addr(misalign_addr),
    .predecessor(predecessor), .successor(successor),
    .fence_busy(fence_busy), .fence_done(fence_done),
    .fence_count(fence_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int txn   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_pred, m_succ, m_maddr;
  int          m_cnt;
  bit          m_redir, m_mis, m_done, m_drain, m_resume;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, exp);
    end
  endtask

  function automatic bit branch_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    bit          tk;
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_pred = 0; m_succ = 0; m_maddr = 0; m_cnt = 0;
      m_redir = 0; m_mis = 0; m_done = 0; m_drain = 0; m_resume = 0;
      return;
    end
    m_redir = 0; m_mis = 0; m_done = 0;
    if (m_resume) begin
      m_pc = m_succ; m_done = 1; m_resume = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_drain) begin
      if (mem_idle) begin m_drain = 0; m_resume = 1; end
    end else if (!stall) begin
      tk  = jump || (branch && branch_taken(funct3, op_a, op_b));
      tgt = (jump && jalr) ? (alu_out & ~32'h1) : m_pc + imm;
      if (tk) begin
        if ((tgt % 4) >= 2) begin
          m_pc = 32'h100; m_mis = 1; m_maddr = tgt;
        end else begin
          m_pc = tgt; m_redir = 1;
        end
      end else if (fence) begin
        m_pred = m_pc; m_succ = m_pc + 4; m_drain = 1;
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    txn++;
    $display("txn %0d rst=%b stall=%b br=%b j=%b jr=%b fence=%b midle=%b -> pc=%h redir=%b mis=%b busy=%b done=%b cnt=%0d",
             txn, reset, stall, branch, jump, jalr, fence, mem_idle,
             pc, redirect, misalign, fence_busy, fence_done, fence_count);
    chk("pc", pc, m_pc);
    chk("next_pc", next_pc, m_pc + 32'd4);
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("misalign_addr", misalign_addr, m_maddr);
    chk("predecessor", predecessor, m_pred);
    chk("successor", successor, m_succ);
    chk("fence_busy", 32'(fence_busy), 32'(m_drain | m_resume));
    chk("fence_done", 32'(fence_done), 32'(m_done));
    chk("fence_count", 32'(fence_count), 32'(m_cnt));
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branch = 0; jump = 0; jalr = 0; funct3 = 3'd2;
    op_a = 0; op_b = 0; imm = 0; alu_out = 0; fence = 0; mem_idle = 0;
  endtask

  typedef struct {
    logic        rst, stl, br, jp, jr;
    logic [2:0]  f3;
    logic [31:0] a, b, im, alu;
    logic        fn, mi;
    logic [31:0] e_pc;
    logic        e_redir, e_mis;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic stl, logic br, logic jp, logic jr,
                              logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                              logic [31:0] im, logic [31:0] alu,
                              logic [31:0] e_pc, logic e_redir, logic e_mis);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.jp = jp; v.jr = jr; v.f3 = f3;
    v.a = a; v.b = b; v.im = im; v.alu = alu; v.fn = 1'b0; v.mi = 1'b0;
    v.e_pc = e_pc; v.e_redir = e_redir; v.e_mis = e_mis;
    return v;
  endfunction

  int busy_cycles, done_pulses;

  initial begin
    idle_inputs();
    m_pc = 0; m_pred = 0; m_succ = 0; m_maddr = 0; m_cnt = 0;
    m_redir = 0; m_mis = 0; m_done = 0; m_drain = 0; m_resume = 0;

    //            rst stl br jp jr f3    a  b  imm      alu           exp_pc        r  m
    vecs[0]  = mk(1, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h0,        0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h4,        0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h8,        0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'hC,        0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h10,       0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 0, 3'd6, 1, 2, 32'h20,  0,            32'h30,       1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h34,       0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 1, 3'd2, 0, 0, 0,       32'h10,       32'h10,       1, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 3'd7, 1, 2, 32'h20,  0,            32'h14,       0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 1, 3'd2, 0, 0, 0,       32'h205,      32'h204,      1, 0);
    vecs[10] = mk(0, 0, 0, 1, 1, 3'd2, 0, 0, 0,       32'h206,      32'h100,      0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h104,      0, 0);
    vecs[12] = mk(0, 1, 0, 1, 0, 3'd2, 0, 0, 32'h8,   0,            32'h104,      0, 0);
    vecs[13] = mk(0, 1, 0, 1, 0, 3'd2, 0, 0, 32'h8,   0,            32'h104,      0, 0);
    vecs[14] = mk(0, 1, 0, 1, 0, 3'd2, 0, 0, 32'h8,   0,            32'h104,      0, 0);
    vecs[15] = mk(0, 0, 0, 1, 0, 3'd2, 0, 0, 32'h8,   0,            32'h10C,      1, 0);
    vecs[16] = mk(0, 0, 0, 1, 1, 3'd2, 0, 0, 0,       32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h0,        0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0,       0,            32'h4,        0, 0);

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst; stall = vecs[i].stl; branch = vecs[i].br;
      jump = vecs[i].jp; jalr = vecs[i].jr; funct3 = vecs[i].f3;
      op_a = vecs[i].a; op_b = vecs[i].b; imm = vecs[i].im;
      alu_out = vecs[i].alu; fence = vecs[i].fn; mem_idle = vecs[i].mi;
      step();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
      chk($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
    end
    chk("misalign_addr_0x206", misalign_addr, 32'h206);

    // Fence with mem_idle low for three drain cycles.
    idle_inputs();
    jump = 1; jalr = 1; alu_out = 32'h40;
    step();
    idle_inputs();
    fence = 1; mem_idle = 0;
    busy_cycles = 0; done_pulses = 0;
    step();
    busy_cycles += int'(fence_busy);
    fence = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      busy_cycles += int'(fence_busy);
      done_pulses += int'(fence_done);
    end
    mem_idle = 1;
    for (int k = 0; k < 10 && fence_busy; k++) begin
      step();
      busy_cycles += int'(fence_busy);
      done_pulses += int'(fence_done);
    end
    chk("fence_exit_timeout", 32'(fence_busy), 32'h0);
    chk("fence_busy_cycles", 32'(busy_cycles), 32'd5);
    chk("fence_done_pulses", 32'(done_pulses), 32'd1);
    chk("fence_pc", pc, 32'h44);
    chk("fence_pred", predecessor, 32'h40);
    chk("fence_succ", successor, 32'h44);
    chk("fence_count_1", 32'(fence_count), 32'd1);

    // Reset while draining.
    idle_inputs();
    fence = 1;
    step();
    fence = 0;
    step();
    reset = 1;
    step();
    chk("rst_drain_pc", pc, 32'h0);
    chk("rst_drain_busy", 32'(fence_busy), 32'h0);
    chk("rst_drain_pred", predecessor, 32'h0);
    chk("rst_drain_succ", successor, 32'h0);
    chk("rst_drain_cnt", 32'(fence_count), 32'h0);
    idle_inputs();

    // Saturate the fence counter with minimum-length fences.
    for (int k = 0; k < 260; k++) begin
      fence = 1; mem_idle = 1;
      step();
      fence = 0;
      step();
      step();
    end
    chk("fence_count_sat", 32'(fence_count), 32'd255);

    // Randomized stimulus.
    for (int k = 0; k < 600; k++) begin
      reset    = ($urandom_range(0, 99) < 2);
      stall    = ($urandom_range(0, 99) < 20);
      branch   = 1'($urandom_range(0, 1));
      jump     = ($urandom_range(0, 99) < 15);
      jalr     = 1'($urandom_range(0, 1));
      funct3   = 3'($urandom_range(0, 7));
      op_a     = 32'($urandom_range(0, 3)) - 32'd2;
      op_b     = 32'($urandom_range(0, 3)) - 32'd2;
      imm      = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) imm = -imm;
      alu_out  = $urandom;
      fence    = ($urandom_range(0, 99) < 15);
      mem_idle = 1'($urandom_range(0, 1));
      step();
      chk("pulse_exclusive", 32'(int'(redirect) + int'(misalign) + int'(fence_done) <= 1), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
